yags_dir_predictor: RTL and testbench

Parametrised YAGS direction predictor for the RV32I pipeline's fetch/execute loop. It replaces the fixed-width direction PHT with three structures: a PC-indexed choice PHT plus tagged, set-associative taken/not-taken exception caches. Fetch consults it through a registered read port, and execute trains it through a two-stage read-modify-write update pipeline. A built-in init sweep clears all tables after reset.

---
 rtl/yags_dir_predictor_if.sv | 30 +++
 rtl/yags_dir_predictor.sv | 211 +++++++++++++++++++++
 tb/tb_yags_dir_predictor.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/yags_dir_predictor_if.sv
// rtl/yags_dir_predictor_if.sv - lookup/train bus between the pipeline and the YAGS predictor
interface yags_dir_predictor_if #(
  parameter int PC_SIZE  = 10,
  parameter int GHR_SIZE = 10
);
  logic                ready;
  logic                read_valid;
  logic [PC_SIZE-1:0]  read_address;
  logic [GHR_SIZE-1:0] read_history;
  logic                pred_valid;
  logic                pred_taken;
  logic                pred_hit;
  logic                update;
  logic [PC_SIZE-1:0]  address;
  logic [GHR_SIZE-1:0] history;
  logic                taken;
  logic                miss_predict;

  modport master (
    output read_valid, read_address, read_history,
    output update, address, history, taken, miss_predict,
    input  ready, pred_valid, pred_taken, pred_hit
  );

  modport slave (
    input  read_valid, read_address, read_history,
    input  update, address, history, taken, miss_predict,
    output ready, pred_valid, pred_taken, pred_hit
  );
endinterface

// File: rtl/yags_dir_predictor.sv
// rtl/yags_dir_predictor.sv - YAGS direction predictor: choice PHT plus tagged T/NT exception caches
module yags_dir_predictor #(
  parameter int PC_SIZE     = 10,
  parameter int GHR_SIZE    = 10,
  parameter int CHOICE_BITS = 10,
  parameter int IDX_BITS    = 8,
  parameter int TAG_BITS    = 6,
  parameter int WAYS        = 2,
  parameter int CTR_BITS    = 2
) (
  input logic i_clk,
  input logic i_rst,
  yags_dir_predictor_if.slave bus
);
  localparam int NCH      = 1 << CHOICE_BITS;
  localparam int NSETS    = 1 << IDX_BITS;
  localparam int PTR_BITS = (CHOICE_BITS > IDX_BITS) ? CHOICE_BITS : IDX_BITS;
  localparam logic [PTR_BITS-1:0] PTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] WEAK_T  = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};

  typedef enum logic {S_INIT, S_RUN} state_t;

  function automatic logic [CTR_BITS-1:0] sat(input logic [CTR_BITS-1:0] c, input logic up);
    if (up) return (c == CTR_MAX) ? c : c + 1'b1;
    else    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic other_way(input logic w);
    return (WAYS == 2) ? ~w : 1'b0;
  endfunction

  // Cache index 0 is the taken cache, 1 the not-taken cache.
  logic [CTR_BITS-1:0] r_choice [NCH];
  logic                r_val    [2][WAYS][NSETS];
  logic [TAG_BITS-1:0] r_tag    [2][WAYS][NSETS];
  logic [CTR_BITS-1:0] r_ctr    [2][WAYS][NSETS];
  logic                r_lru    [2][NSETS];

  state_t              r_state, w_state_nxt;
  logic [PTR_BITS-1:0] r_ptr, w_ptr_nxt;
  logic                w_run;

  logic r_pred_valid, r_pred_taken, r_pred_hit;

  logic                   r_s2_valid;
  logic [CHOICE_BITS-1:0] r_s2_ci;
  logic [CTR_BITS-1:0]    r_s2_choice;
  logic                   r_s2_cwe;
  logic                   r_s2_c;
  logic [IDX_BITS-1:0]    r_s2_set;
  logic                   r_s2_way;
  logic [TAG_BITS-1:0]    r_s2_tag;
  logic [CTR_BITS-1:0]    r_s2_ctr;
  logic                   r_s2_lru;

  logic w_unused_ok;
  assign w_unused_ok = ^{bus.miss_predict, bus.read_address, bus.read_history,
                         bus.address, bus.history};

  assign w_run          = (r_state == S_RUN);
  assign bus.ready      = w_run;
  assign bus.pred_valid = r_pred_valid;
  assign bus.pred_taken = r_pred_taken;
  assign bus.pred_hit   = r_pred_hit;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_INIT: begin
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == PTR_MAX) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Read port: choice selects which exception cache may override it.
  logic [CHOICE_BITS-1:0] w_rd_ci;
  logic [IDX_BITS-1:0]    w_rd_set;
  logic [TAG_BITS-1:0]    w_rd_tag;
  logic [CTR_BITS-1:0]    w_rd_ch;
  logic                   w_rd_c, w_rd_hit, w_rd_dir;

  assign w_rd_ci  = bus.read_address[CHOICE_BITS-1:0];
  assign w_rd_set = bus.read_address[IDX_BITS-1:0] ^ bus.read_history[IDX_BITS-1:0];
  assign w_rd_tag = bus.read_address[TAG_BITS-1:0];
  assign w_rd_ch  = r_choice[w_rd_ci];
  assign w_rd_c   = w_rd_ch[CTR_BITS-1];

  always_comb begin
    w_rd_hit = 1'b0;
    w_rd_dir = w_rd_ch[CTR_BITS-1];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_val[w_rd_c][w][w_rd_set] && r_tag[w_rd_c][w][w_rd_set] == w_rd_tag) begin
        w_rd_hit = 1'b1;
        w_rd_dir = r_ctr[w_rd_c][w][w_rd_set][CTR_BITS-1];
      end
    end
  end

  // Update stage U1: table view with the pending U2 write overlaid.
  logic [CHOICE_BITS-1:0] w_ci;
  logic [IDX_BITS-1:0]    w_set;
  logic [TAG_BITS-1:0]    w_tag;
  logic [CTR_BITS-1:0]    w_ch;
  logic                   w_c, w_fwd_set, w_lru;
  logic                   w_val [WAYS];
  logic [TAG_BITS-1:0]    w_etag [WAYS];
  logic [CTR_BITS-1:0]    w_ectr [WAYS];

  assign w_ci      = bus.address[CHOICE_BITS-1:0];
  assign w_set     = bus.address[IDX_BITS-1:0] ^ bus.history[IDX_BITS-1:0];
  assign w_tag     = bus.address[TAG_BITS-1:0];
  assign w_ch      = (r_s2_valid && r_s2_ci == w_ci) ? r_s2_choice : r_choice[w_ci];
  assign w_c       = w_ch[CTR_BITS-1];
  assign w_fwd_set = r_s2_valid && r_s2_cwe && (r_s2_c == w_c) && (r_s2_set == w_set);
  assign w_lru     = w_fwd_set ? r_s2_lru : r_lru[w_c][w_set];

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      w_val[w]  = r_val[w_c][w][w_set];
      w_etag[w] = r_tag[w_c][w][w_set];
      w_ectr[w] = r_ctr[w_c][w][w_set];
      if (w_fwd_set && r_s2_way == 1'(w)) begin
        w_val[w]  = 1'b1;
        w_etag[w] = r_s2_tag;
        w_ectr[w] = r_s2_ctr;
      end
    end
  end

  logic                w_hit, w_hway, w_vict, w_cwe, w_way, w_nlru;
  logic [CTR_BITS-1:0] w_hctr, w_nctr, w_nch;

  always_comb begin
    w_hit  = 1'b0;
    w_hway = 1'b0;
    w_hctr = '0;
    w_vict = (WAYS == 2) ? w_lru : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_val[w] && w_etag[w] == w_tag) begin
        w_hit  = 1'b1;
        w_hway = 1'(w);
        w_hctr = w_ectr[w];
      end
      if (!w_val[w]) w_vict = 1'(w);
    end
  end

  assign w_cwe  = w_hit || (w_c != bus.taken);
  assign w_way  = w_hit ? w_hway : w_vict;
  assign w_nctr = w_hit ? sat(w_hctr, bus.taken) : (bus.taken ? WEAK_T : WEAK_NT);
  assign w_nlru = other_way(w_way);
  // A correct exception entry keeps the choice entry biased the other way.
  assign w_nch  = (w_hit && w_hctr[CTR_BITS-1] == bus.taken && w_c != bus.taken) ?
                  w_ch : sat(w_ch, bus.taken);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_INIT;
      r_ptr        <= '0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_hit   <= 1'b0;
      r_s2_valid   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_pred_valid <= w_run && bus.read_valid;
      r_pred_taken <= w_run && bus.read_valid && w_rd_dir;
      r_pred_hit   <= w_run && bus.read_valid && w_rd_hit;
      r_s2_valid   <= w_run && bus.update;
    end
    r_s2_ci     <= w_ci;
    r_s2_choice <= w_nch;
    r_s2_cwe    <= w_cwe;
    r_s2_c      <= w_c;
    r_s2_set    <= w_set;
    r_s2_way    <= w_way;
    r_s2_tag    <= w_tag;
    r_s2_ctr    <= w_nctr;
    r_s2_lru    <= w_nlru;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == S_INIT) begin
        r_choice[r_ptr[CHOICE_BITS-1:0]] <= WEAK_T;
        for (int c = 0; c < 2; c++) begin
          r_lru[c][r_ptr[IDX_BITS-1:0]] <= 1'b0;
          for (int w = 0; w < WAYS; w++) begin
            r_val[c][w][r_ptr[IDX_BITS-1:0]] <= 1'b0;
            r_tag[c][w][r_ptr[IDX_BITS-1:0]] <= '0;
            r_ctr[c][w][r_ptr[IDX_BITS-1:0]] <= WEAK_NT;
          end
        end
      end else if (r_s2_valid) begin
        r_choice[r_s2_ci] <= r_s2_choice;
        if (r_s2_cwe) begin
          r_val[r_s2_c][r_s2_way][r_s2_set] <= 1'b1;
          r_tag[r_s2_c][r_s2_way][r_s2_set] <= r_s2_tag;
          r_ctr[r_s2_c][r_s2_way][r_s2_set] <= r_s2_ctr;
          r_lru[r_s2_c][r_s2_set]           <= r_s2_lru;
        end
      end
    end
  end
endmodule

// File: tb/tb_yags_dir_predictor.sv
// tb/tb_yags_dir_predictor.sv - scoreboard bench for yags_dir_predictor
module tb_yags_dir_predictor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  yags_dir_predictor_if #(.PC_SIZE(10), .GHR_SIZE(10)) bus();

  yags_dir_predictor dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    logic  t;
    logic  h;
    string name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (bus.pred_valid === 1'b1) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pred: pred_valid=1 with no outstanding request");
      end else begin
        e = q.pop_front();
        if ({bus.pred_taken, bus.pred_hit} !== {e.t, e.h}) begin
          n_fail++;
          $display("FAIL %s: got taken=%0b hit=%0b, expected taken=%0b hit=%0b",
                   e.name, bus.pred_taken, bus.pred_hit, e.t, e.h);
        end
      end
    end
  end

  task automatic idle(input int n);
    bus.read_valid = 1'b0;
    bus.update     = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic upd(input logic [9:0] a, input logic [9:0] h, input logic t);
    bus.read_valid   = 1'b0;
    bus.update       = 1'b1;
    bus.address      = a;
    bus.history      = h;
    bus.taken        = t;
    bus.miss_predict = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic rd(input logic [9:0] a, input logic [9:0] h,
                    input logic et, input logic eh, input string name);
    exp_t e;
    bus.update       = 1'b0;
    bus.read_valid   = 1'b1;
    bus.read_address = a;
    bus.read_history = h;
    e.t = et;
    e.h = eh;
    e.name = name;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Requests reads throughout init; none may produce pred_valid.
  task automatic do_reset(input string name);
    int cyc;
    bit pv_seen;
    rst            = 1'b1;
    bus.read_valid = 1'b0;
    bus.update     = 1'b0;
    @(negedge clk);
    rst              = 1'b0;
    bus.read_valid   = 1'b1;
    bus.read_address = 10'h012;
    bus.read_history = 10'h001;
    cyc     = 0;
    pv_seen = (bus.pred_valid !== 1'b0);
    while (bus.ready !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (bus.pred_valid !== 1'b0) pv_seen = 1'b1;
    end
    bus.read_valid = 1'b0;
    n_tests++;
    if (cyc != 1024) begin
      n_fail++;
      $display("FAIL %s_ready_delay: ready after %0d cycles, expected 1024", name, cyc);
    end
    n_tests++;
    if (pv_seen) begin
      n_fail++;
      $display("FAIL %s_no_pred_in_init: pred_valid seen=1, expected 0", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    bus.read_valid   = 1'b0;
    bus.read_address = '0;
    bus.read_history = '0;
    bus.update       = 1'b0;
    bus.address      = '0;
    bus.history      = '0;
    bus.taken        = 1'b0;
    bus.miss_predict = 1'b0;
    repeat (2) @(negedge clk);

    do_reset("init1");
    rd(10'h012, 10'h001, 1'b1, 1'b0, "reset_default");
    idle(2);

    upd(10'h0FE, 10'h001, 1'b1);
    upd(10'h0FE, 10'h001, 1'b1);
    upd(10'h0FE, 10'h001, 1'b0);
    idle(2);
    rd(10'h0FE, 10'h001, 1'b0, 1'b1, "alloc_nt_hit");
    idle(2);

    upd(10'h011, 10'h001, 1'b0);
    upd(10'h011, 10'h001, 1'b0);
    upd(10'h011, 10'h001, 1'b0);
    idle(2);
    rd(10'h011, 10'h001, 1'b0, 1'b0, "fwd_choice_00");
    idle(2);

    upd(10'h020, 10'h000, 1'b0);
    rd(10'h020, 10'h000, 1'b1, 1'b0, "rw_old");
    rd(10'h020, 10'h000, 1'b0, 1'b0, "rw_new");
    idle(2);

    upd(10'h030, 10'h000, 1'b0);
    do_reset("init2");
    rd(10'h030, 10'h000, 1'b1, 1'b0, "rst_discard");
    idle(2);

    upd(10'h011, 10'h000, 1'b1);
    upd(10'h012, 10'h003, 1'b1);
    upd(10'h013, 10'h002, 1'b1);
    upd(10'h011, 10'h000, 1'b0);
    upd(10'h012, 10'h003, 1'b0);
    upd(10'h013, 10'h002, 1'b0);
    idle(2);
    rd(10'h012, 10'h003, 1'b0, 1'b1, "lru_hit_012");
    rd(10'h013, 10'h002, 1'b0, 1'b1, "lru_hit_013");
    rd(10'h011, 10'h000, 1'b1, 1'b0, "lru_evict_011");
    idle(4);

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_preds: %0d predictions never arrived, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
